// File: rtl/mc_ctrl.sv
// mc_ctrl: main control sequencer for the multicycle MIPS-subset datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB, drives every datapath enable and mux
// select combinationally from the current state and the latched IR fields,
// stalls on the memory ready handshake and counts retired instructions.
module mc_ctrl #(
   parameter int CNT_W    = 32,
   parameter int LINK_REG = 31
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_we,
   output logic             mdr_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             reg_we,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wb_sel,
   output logic             alu_src_b,
   output logic [2:0]       alu_op,
   output logic             ext_zero,
   output logic [2:0]       state,
   output logic             trap,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   // A link register of 0 targets the hardwired $zero, so JAL skips its write.
   localparam logic LinkWrites = (LINK_REG != 0);

   state_e           state_q, state_d;
   logic             trap_q, trap_d;
   logic [CNT_W-1:0] retired_q;
   logic             retire;

   // Instruction decode of the latched IR fields.
   logic is_r, r_add, r_sub, r_slt, r_jr;
   logic is_lw, is_sw, is_j, is_jal, is_beq, is_bne, is_addi, is_xori, legal;

   assign is_r    = (opcode == 6'h00);
   assign r_add   = is_r && (funct == 6'h20);
   assign r_sub   = is_r && (funct == 6'h22);
   assign r_slt   = is_r && (funct == 6'h2A);
   assign r_jr    = is_r && (funct == 6'h08);
   assign is_lw   = (opcode == 6'h23);
   assign is_sw   = (opcode == 6'h2B);
   assign is_j    = (opcode == 6'h02);
   assign is_jal  = (opcode == 6'h03);
   assign is_beq  = (opcode == 6'h04);
   assign is_bne  = (opcode == 6'h05);
   assign is_addi = (opcode == 6'h08);
   assign is_xori = (opcode == 6'h0E);
   assign legal   = r_add | r_sub | r_slt | r_jr | is_lw | is_sw | is_j |
                    is_jal | is_beq | is_bne | is_addi | is_xori;

   // Next-state and control decode; reset forces every strobe low at once so
   // an aborted memory request is dropped without waiting for the clock.
   always_comb begin
      state_d   = state_q;
      retire    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      mdr_we    = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      reg_we    = 1'b0;
      reg_dst   = 2'd0;
      wb_sel    = 2'd0;
      alu_src_b = 1'b0;
      alu_op    = 3'd0;
      ext_zero  = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_we   = 1'b1;
                  pc_we   = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               if (is_j || is_jal) begin
                  pc_we   = 1'b1;
                  pc_src  = 2'd2;
                  retire  = is_j;
                  state_d = is_j ? S_FETCH : S_WB;
               end else if (r_jr) begin
                  pc_we   = 1'b1;
                  pc_src  = 2'd3;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else if (!legal) begin
                  state_d = S_TRAP;
               end else begin
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_r) begin
                  alu_op  = r_sub ? 3'd1 : (r_slt ? 3'd2 : 3'd0);
                  state_d = S_WB;
               end else if (is_addi) begin
                  alu_src_b = 1'b1;
                  state_d   = S_WB;
               end else if (is_xori) begin
                  alu_op    = 3'd3;
                  alu_src_b = 1'b1;
                  ext_zero  = 1'b1;
                  state_d   = S_WB;
               end else if (is_lw || is_sw) begin
                  alu_src_b = 1'b1;
                  state_d   = S_MEM;
               end else begin
                  // Branches: compare via SUB and redirect on the zero flag.
                  alu_op  = 3'd1;
                  pc_we   = (is_beq && alu_zero) || (is_bne && !alu_zero);
                  pc_src  = pc_we ? 2'd1 : 2'd0;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_MEM: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = is_sw;
               if (mem_ready) begin
                  mdr_we  = is_lw;
                  retire  = is_sw;
                  state_d = is_sw ? S_FETCH : S_WB;
               end
            end
            S_WB: begin
               reg_we  = is_jal ? LinkWrites : 1'b1;
               reg_dst = is_jal ? 2'd2 : (is_r ? 2'd1 : 2'd0);
               wb_sel  = is_jal ? 2'd2 : (is_lw ? 2'd1 : 2'd0);
               retire  = 1'b1;
               state_d = S_FETCH;
            end
            default: state_d = S_TRAP;
         endcase
      end
      trap_d = trap_q || (state_d == S_TRAP);
   end

   // State, sticky trap flag and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         trap_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         trap_q  <= trap_d;
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign state   = state_q;
   assign trap    = trap_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: builds the expected per-cycle control vector of each
// instruction from its class and wait counts, checks every cycle, and pins
// the model with literal cycle counts and retired values.
module tb_mc_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [5:0]    opcode, funct;
   logic          alu_zero, mem_ready;
   logic          mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we;
   logic [1:0]    pc_src, reg_dst, wb_sel;
   logic          reg_we, alu_src_b, ext_zero, trap;
   logic [2:0]    alu_op, state;
   logic [CW-1:0] retired;

   mc_ctrl #(.CNT_W(CW), .LINK_REG(31)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
      .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .mdr_we(mdr_we),
      .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
      .wb_sel(wb_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .ext_zero(ext_zero), .state(state), .trap(trap), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we;
      logic [1:0] pc_src;
      logic       reg_we;
      logic [1:0] reg_dst, wb_sel;
      logic       alu_src_b;
      logic [2:0] alu_op;
      logic       ext_zero;
      logic [2:0] state;
      logic       trap;
   } ctl_t;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc_n   = 0;
   logic [CW-1:0] m_retired = '0;
   logic          junk_rdy = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // One clock cycle: drive, compare all outputs against the model, advance.
   task automatic step(input logic rdy, input ctl_t e, input bit ret);
      ctl_t a;
      mem_ready = rdy;
      #1;
      a = '{mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_src, reg_we,
            reg_dst, wb_sel, alu_src_b, alu_op, ext_zero, state, trap};
      n_tests++;
      if (a !== e || retired !== m_retired) begin
         n_fail++;
         $display("FAIL cycle[%0d] op=%h fn=%h: ctl got %h want %h, retired got %0d want %0d",
                  cyc_n, opcode, funct, a, e, retired, m_retired);
      end
      cyc_n++;
      @(posedge clk);
      if (ret) m_retired = m_retired + 1'b1;
      @(negedge clk);
   endtask

   // Expected behaviour of one whole instruction, from its class.
   task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                             input int fw, input int mw, input int exp_cycles);
      ctl_t e;
      int   start;
      bit   r, lw, sw, legal, taken;
      start    = cyc_n;
      opcode   = op;
      funct    = fn;
      alu_zero = zero;
      r  = (op == 6'h00);
      lw = (op == 6'h23);
      sw = (op == 6'h2B);
      case (op)
         6'h00:   legal = (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A || fn == 6'h08);
         6'h23, 6'h2B, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0E: legal = 1'b1;
         default: legal = 1'b0;
      endcase
      // fetch, with wait states
      e = '0; e.mem_req = 1'b1;
      repeat (fw) step(1'b0, e, 1'b0);
      e.ir_we = 1'b1; e.pc_we = 1'b1;
      step(1'b1, e, 1'b0);
      // decode
      e = '0; e.state = 3'd1;
      if (op == 6'h02 || (r && fn == 6'h08)) begin
         e.pc_we = 1'b1; e.pc_src = (op == 6'h02) ? 2'd2 : 2'd3;
         step(junk_rdy, e, 1'b1);
      end else if (op == 6'h03) begin
         e.pc_we = 1'b1; e.pc_src = 2'd2;
         step(junk_rdy, e, 1'b0);
         e = '0; e.state = 3'd4; e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wb_sel = 2'd2;
         step(junk_rdy, e, 1'b1);
      end else if (!legal) begin
         step(junk_rdy, e, 1'b0);
         e = '0; e.state = 3'd5; e.trap = 1'b1;
         repeat (10) step(junk_rdy, e, 1'b0);
      end else begin
         step(junk_rdy, e, 1'b0);
         // execute
         e = '0; e.state = 3'd2;
         if (op == 6'h04 || op == 6'h05) begin
            taken    = (op == 6'h04) ? zero : !zero;
            e.alu_op = 3'd1;
            e.pc_we  = taken;
            e.pc_src = taken ? 2'd1 : 2'd0;
            step(junk_rdy, e, 1'b1);
         end else begin
            if (r) e.alu_op = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd2 : 3'd0;
            else begin
               e.alu_src_b = 1'b1;
               if (op == 6'h0E) begin e.alu_op = 3'd3; e.ext_zero = 1'b1; end
            end
            step(junk_rdy, e, 1'b0);
            // memory access
            if (lw || sw) begin
               e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = sw;
               repeat (mw) step(1'b0, e, 1'b0);
               e.mdr_we = lw;
               step(1'b1, e, sw);
            end
            // write-back
            if (!sw) begin
               e = '0; e.state = 3'd4; e.reg_we = 1'b1;
               e.reg_dst = r ? 2'd1 : 2'd0;
               e.wb_sel  = lw ? 2'd1 : 2'd0;
               step(junk_rdy, e, 1'b1);
            end
         end
      end
      chk($sformatf("cycles op=%h fn=%h", op, fn), 32'(cyc_n - start), 32'(exp_cycles));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst state", 32'(state), 32'd0);
      chk("rst trap", 32'(trap), 32'd0);
      chk("rst retired", 32'(retired), 32'd0);
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      m_retired = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      ctl_t e;
      reset = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      do_reset();

      exec_instr(6'h00, 6'h20, 1'b0, 0, 0, 4);          // ADD
      chk("retired after ADD", 32'(retired), 32'd1);
      exec_instr(6'h23, 6'h00, 1'b0, 2, 2, 9);          // LW with waits
      exec_instr(6'h04, 6'h00, 1'b1, 0, 0, 3);          // BEQ taken
      exec_instr(6'h05, 6'h00, 1'b1, 0, 0, 3);          // BNE not taken
      chk("retired after branches", 32'(retired), 32'd4);
      junk_rdy = 1'b1;                                   // ready noise outside FETCH/MEM
      exec_instr(6'h03, 6'h00, 1'b0, 0, 0, 3);          // JAL
      exec_instr(6'h00, 6'h08, 1'b0, 0, 0, 2);          // JR
      exec_instr(6'h00, 6'h22, 1'b0, 1, 0, 5);          // SUB
      exec_instr(6'h00, 6'h2A, 1'b0, 0, 0, 4);          // SLT
      exec_instr(6'h08, 6'h3F, 1'b0, 0, 0, 4);          // ADDI
      exec_instr(6'h0E, 6'h00, 1'b0, 0, 0, 4);          // XORI
      exec_instr(6'h2B, 6'h00, 1'b0, 0, 1, 5);          // SW
      exec_instr(6'h05, 6'h00, 1'b0, 0, 0, 3);          // BNE taken
      exec_instr(6'h04, 6'h00, 1'b0, 0, 0, 3);          // BEQ not taken
      junk_rdy = 1'b0;
      exec_instr(6'h02, 6'h00, 1'b0, 0, 0, 2);          // J
      chk("retired before wrap", 32'(retired), 32'd14);
      exec_instr(6'h02, 6'h00, 1'b0, 0, 0, 2);
      chk("retired at max", 32'(retired), 32'd15);
      exec_instr(6'h02, 6'h00, 1'b0, 0, 0, 2);
      chk("retired wrapped", 32'(retired), 32'd0);
      exec_instr(6'h00, 6'h20, 1'b0, 0, 0, 4);
      chk("retired after wrap", 32'(retired), 32'd1);

      // SW aborted by reset in the middle of a memory stall
      opcode = 6'h2B; funct = 6'h00;
      e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
      step(1'b1, e, 1'b0);
      e = '0; e.state = 3'd1;
      step(1'b0, e, 1'b0);
      e = '0; e.state = 3'd2; e.alu_src_b = 1'b1;
      step(1'b0, e, 1'b0);
      e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = 1'b1;
      step(1'b0, e, 1'b0);
      mem_ready = 1'b0;
      do_reset();

      // illegal opcode traps, then reset clears everything
      exec_instr(6'h3F, 6'h00, 1'b0, 0, 0, 12);
      chk("trap sticky", 32'(trap), 32'd1);
      chk("trap state", 32'(state), 32'd5);
      do_reset();
      exec_instr(6'h00, 6'h33, 1'b0, 0, 0, 12);         // illegal R-type funct
      do_reset();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Main control sequencer for the team's multicycle MIPS-subset CPU datapath (PC, IR, MDR, register file, ALU, unified memory).
- Decodes the latched IR opcode/funct and steps through the FETCH, DECODE, EXEC, MEM and WB states.
- Drives every datapath enable and mux select each cycle.
- Stalls on a single-port memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- LINK_REG, 31, register index written by JAL

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualifies mem_req
- addr_sel  out  1  0=PC, 1=ALU result register
- ir_we  out  1  load IR
- mdr_we  out  1  load MDR
- pc_we  out  1  load PC
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs (JR)
- reg_we  out  1  register-file write
- reg_dst  out  2  0=rt, 1=rd, 2=LINK_REG
- wb_sel  out  2  0=ALU result, 1=MDR, 2=PC+4 (link)
- alu_src_b  out  1  0=rt, 1=sign-extended immediate
- alu_op  out  3  0=ADD, 1=SUB, 2=SLT, 3=XOR
- ext_zero  out  1  1=zero-extend immediate (XORI)
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
- trap  out  1  illegal instruction seen (sticky)
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - state=FETCH, trap=0, retired=0.
  - All enables/strobes are 0 and all selects are 0 on any cycle not listed below.
  - Reset mid-stall aborts the request; mem_req=0 in the cycle after reset.
- Control outputs are combinational from state and decode. state, trap and retired are registered.
- Opcodes: R-type 0x00, with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08. LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, ADDI 0x08, XORI 0x0E. Anything else is illegal.
- FETCH:
  - mem_req=1, addr_sel=0.
  - While mem_ready=0, hold state with no other enables.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0, next DECODE.
- DECODE:
  - J: pc_we=1, pc_src=2, retire, next FETCH.
  - JR: pc_we=1, pc_src=3, retire, next FETCH.
  - JAL: pc_we=1, pc_src=2, next WB.
  - Illegal: next TRAP.
  - Others: next EXEC.
- EXEC:
  - R-type: alu_op from funct, alu_src_b=0, next WB.
  - ADDI: alu_op=ADD, alu_src_b=1, next WB.
  - XORI: alu_op=XOR, alu_src_b=1, ext_zero=1, next WB.
  - LW/SW: alu_op=ADD, alu_src_b=1, next MEM.
  - BEQ/BNE: alu_op=SUB, alu_src_b=0; pc_we=1, pc_src=1 iff (BEQ and alu_zero) or (BNE and !alu_zero); retire, next FETCH.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=(SW).
  - Hold while mem_ready=0; mem_we stays asserted throughout the stall.
  - On mem_ready: LW sets mdr_we=1 and goes to WB; SW retires and goes to FETCH.
- WB: reg_we=1 for exactly one cycle, retire, next FETCH.
  - R-type: reg_dst=1, wb_sel=0.
  - ADDI/XORI: reg_dst=0, wb_sel=0.
  - LW: reg_dst=0, wb_sel=1.
  - JAL: reg_dst=2, wb_sel=2.
- TRAP: all enables 0, trap=1; stays in TRAP until reset.
- Retire: retired increments by 1 on the cycle that leaves the final state of an instruction. It wraps modulo 2^CNT_W.
- Cycle counts with zero wait states:
  - J/JR: 2
  - BEQ/BNE/JAL: 3
  - R-type/ADDI/XORI/SW: 4
  - LW: 5
  - Each wait cycle adds 1.
- mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset, then ADD (op 0, funct 0x20), mem_ready=1 -> states 0,1,2,4,0; WB shows reg_we=1, reg_dst=1, wb_sel=0, alu_op=0; retired=1.
- LW with mem_ready low for 2 cycles in each of FETCH and MEM -> 9 cycles total; mdr_we pulses once on the MEM ready cycle; WB shows wb_sel=1, reg_dst=0.
- BEQ with alu_zero=1 then BNE with alu_zero=1 -> pc_we=1, pc_src=1 in EXEC only for BEQ; retired increments by 2.
- JAL -> DECODE shows pc_we=1, pc_src=2; WB shows reg_dst=2, wb_sel=2; 3 cycles; then JR -> pc_src=3, 2 cycles.
- Opcode 0x3F -> TRAP, trap=1, no enables for 10 cycles; reset -> state=0, trap=0, retired=0.
- SW in a MEM stall with reset asserted -> next cycle state=0, mem_req=0, mem_we=0; retired preloaded to 2^CNT_W-1 wraps to 0 on the next retire.
